// File: rtl/ram_pipe_pkg.sv
// Shared constants, helper function and stage-record type for the pipelined 1W/1R RAM.
// Optional macro RAM_WR_BYPASS_EN (used by the top) selects write-first collision data.
`ifndef RAM_PIPE_PKG_SV
`define RAM_PIPE_PKG_SV

// Width-parameterised {valid, data} stage record; expands to a packed struct type.
`define RAM_STAGE_T(W) struct packed { logic valid; logic [(W)-1:0] data; }

package ram_pipe_pkg;

    localparam int RAM_LAT_MIN = 1;
    localparam int RAM_LAT_MAX = 2;

    // Address width that stays at least one bit for tiny depths.
    function automatic int clog2s(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

`endif

// File: rtl/ram_pipe_stage.sv
// One valid/data pipeline register with a valid/ready handshake on both sides.
// It accepts a new word whenever it is empty or its current word leaves this cycle.
module ram_pipe_stage
    import ram_pipe_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    typedef `RAM_STAGE_T(W) stage_t;

    stage_t q;

    assign in_ready  = !q.valid || out_ready;
    assign out_valid = q.valid;
    assign out_data  = q.data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (in_valid && in_ready) begin
            q <= '{valid: 1'b1, data: in_data};
        end else if (out_ready) begin
            q.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_1clk_1w_1r_pipe.sv
// Single-clock 1W/1R RAM with byte-enable writes and a 1- or 2-stage valid/ready read pipeline.
// Define RAM_WR_BYPASS_EN for write-first data on a same-address write/read collision.
module ram_1clk_1w_1r_pipe
    import ram_pipe_pkg::*;
#(
    parameter  int C_RAM_WIDTH    = 32,
    parameter  int C_RAM_DEPTH    = 1024,
    parameter  int C_READ_LATENCY = 2,
    localparam int AW             = clog2s(C_RAM_DEPTH),
    localparam int NB             = C_RAM_WIDTH / 8
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   WR_EN,
    input  logic [AW-1:0]          WR_ADDR,
    input  logic [C_RAM_WIDTH-1:0] WR_DATA,
    input  logic [NB-1:0]          WR_BE,
    input  logic                   RD_EN,
    input  logic [AW-1:0]          RD_ADDR,
    output logic                   RD_ACCEPT,
    output logic [C_RAM_WIDTH-1:0] RD_DATA,
    output logic                   RD_VALID,
    input  logic                   RD_READY
);

    typedef `RAM_STAGE_T(C_RAM_WIDTH) stage_t;

    if (C_READ_LATENCY < RAM_LAT_MIN || C_READ_LATENCY > RAM_LAT_MAX) begin : g_bad_latency
        $error("C_READ_LATENCY must be 1 or 2");
    end
    if (C_RAM_WIDTH % 8 != 0) begin : g_bad_width
        $error("C_RAM_WIDTH must be a multiple of 8");
    end

    logic [C_RAM_WIDTH-1:0] mem [C_RAM_DEPTH];
    logic [C_RAM_WIDTH-1:0] rd_word;
    stage_t                 s1;        // BRAM output register
    logic                   s1_ready;  // whatever follows stage 1 can take its word
    logic                   rd_take;

`ifdef RAM_WR_BYPASS_EN
    // Write-first: bytes being written this edge override the stored bytes.
    always_comb begin
        rd_word = mem[RD_ADDR];
        if (WR_EN && (WR_ADDR == RD_ADDR)) begin
            for (int i = 0; i < NB; i++) begin
                if (WR_BE[i]) rd_word[8*i +: 8] = WR_DATA[8*i +: 8];
            end
        end
    end
`else
    // Read-first: the array read sees the word as it was before this edge's write.
    assign rd_word = mem[RD_ADDR];
`endif

    assign RD_ACCEPT = !s1.valid || s1_ready;
    assign rd_take   = RD_EN && RD_ACCEPT;

    // NOTE: the array has no reset; only the output register clears, and writes
    // sit in the non-reset branch so they are suppressed while RST_N is low.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1 <= '0;
        end else begin
            if (WR_EN) begin
                for (int i = 0; i < NB; i++) begin
                    if (WR_BE[i]) mem[WR_ADDR][8*i +: 8] <= WR_DATA[8*i +: 8];
                end
            end
            if (rd_take) begin
                s1 <= '{valid: 1'b1, data: rd_word};
            end else if (s1_ready) begin
                s1.valid <= 1'b0;
            end
        end
    end

    if (C_READ_LATENCY == 1) begin : g_lat1
        assign s1_ready = RD_READY;
        assign RD_VALID = s1.valid;
        assign RD_DATA  = s1.data;
    end else begin : g_lat2
        ram_pipe_stage #(
            .W (C_RAM_WIDTH)
        ) u_stage2 (
            .clk       (CLK),
            .rst_n     (RST_N),
            .in_valid  (s1.valid),
            .in_ready  (s1_ready),
            .in_data   (s1.data),
            .out_valid (RD_VALID),
            .out_ready (RD_READY),
            .out_data  (RD_DATA)
        );
    end

endmodule

// File: tb/tb_ram_1clk_1w_1r_pipe.sv
// Self-checking bench for ram_1clk_1w_1r_pipe: byte-enable table, streaming, stall,
// collision (RAM_WR_BYPASS_EN aware), mid-flight reset and stalled-word hold.
module tb_ram_1clk_1w_1r_pipe;

    localparam int W     = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int LAT   = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [3:0]    wr_be;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_accept;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          rd_ready;

    ram_1clk_1w_1r_pipe #(
        .C_RAM_WIDTH    (W),
        .C_RAM_DEPTH    (DEPTH),
        .C_READ_LATENCY (LAT)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .WR_EN     (wr_en),
        .WR_ADDR   (wr_addr),
        .WR_DATA   (wr_data),
        .WR_BE     (wr_be),
        .RD_EN     (rd_en),
        .RD_ADDR   (rd_addr),
        .RD_ACCEPT (rd_accept),
        .RD_DATA   (rd_data),
        .RD_VALID  (rd_valid),
        .RD_READY  (rd_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n === 1'b1 && rd_en === 1'b1)
            assert (int'(rd_addr) < DEPTH) else $error("read address out of range");
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at 200000 ns, required completion");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference memory and in-order scoreboard of accepted reads.
    logic [W-1:0] model [DEPTH];
    logic [W-1:0] exp_q [$];
    int           acc_q [$];

    // Per-edge samples, taken mid-cycle just before the edge they describe.
    int           cyc = 0;
    int           s_cyc;
    logic         s_acc, s_xfer;
    logic [W-1:0] s_data;

    task automatic cycle();
        #2;
        s_acc  = rd_en && rd_accept;
        s_xfer = rd_valid && rd_ready;
        s_data = rd_data;
        s_cyc  = cyc;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_write(input int addr, input logic [W-1:0] data, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data; wr_be = be;
        cycle();
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++)
            if (be[i]) model[addr][8*i +: 8] = data[8*i +: 8];
    endtask

    task automatic wait_beat(output logic [W-1:0] data, output logic ok);
        ok = 1'b0;
        data = '0;
        for (int c = 0; c < 20 && !ok; c++) begin
            cycle();
            if (s_xfer) begin
                data = s_data;
                ok = 1'b1;
            end
        end
    endtask

    task automatic read_one(input int addr, input logic [W-1:0] exp, input string name);
        logic         acc = 1'b0;
        logic         ok;
        logic [W-1:0] d;
        rd_ready = 1'b1; rd_en = 1'b1; rd_addr = AW'(addr);
        for (int c = 0; c < 20 && !acc; c++) begin
            cycle();
            acc = s_acc;
        end
        rd_en = 1'b0;
        check({name, "_accept"}, acc, 1'b1);
        wait_beat(d, ok);
        check({name, "_beat"}, ok, 1'b1);
        check(name, d, exp);
    endtask

    int got;

    // Retire one beat against the scoreboard, also checking accept-to-beat latency.
    task automatic retire(input string name, input logic chk_lat);
        int a;
        if (s_xfer) begin
            if (exp_q.size() == 0) begin
                check({name, "_spurious_beat"}, s_xfer, 1'b0);
            end else begin
                check({name, "_data"}, s_data, exp_q.pop_front());
                a = acc_q.pop_front();
                if (chk_lat) check({name, "_latency"}, s_cyc - a, LAT);
                got++;
            end
        end
    endtask

    typedef struct {
        int          addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } wr_vec_t;

    wr_vec_t vecs [8];

    initial begin
        int           nxt, first_beat, last_beat, first_acc, last_acc, unstable, extra;
        logic [W-1:0] d, old_word;
        logic         ok;

        vecs[0] = '{5,    32'hAABBCCDD, 4'hF, 32'hAABBCCDD};
        vecs[1] = '{5,    32'h11223344, 4'h5, 32'hAA22CC44};
        vecs[2] = '{5,    32'h00000000, 4'h0, 32'hAA22CC44};
        vecs[3] = '{5,    32'h99887766, 4'h8, 32'h9922CC44};
        vecs[4] = '{1023, 32'h12345678, 4'hF, 32'h12345678};
        vecs[5] = '{1023, 32'hDEADBEEF, 4'h2, 32'h1234BE78};
        vecs[6] = '{0,    32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF};
        vecs[7] = '{0,    32'h00000000, 4'hA, 32'h00FF00FF};

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0; rd_ready = 1'b0;
        #1;
        check("reset_rd_valid", rd_valid, 1'b0);
        check("reset_rd_data", rd_data, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        check("post_reset_rd_valid", rd_valid, 1'b0);
        check("post_reset_rd_accept", rd_accept, 1'b1);

        // Streaming: 16 writes, then 16 back-to-back reads at full throughput.
        for (int a = 0; a < 16; a++) do_write(a, a * 32'h01010101, 4'hF);
        rd_ready = 1'b1; nxt = 0; got = 0;
        first_beat = -1; last_beat = -1; first_acc = -1; last_acc = -1;
        for (int c = 0; c < 60 && got < 16; c++) begin
            rd_en = (nxt < 16); rd_addr = AW'(nxt);
            cycle();
            if (s_acc) begin
                exp_q.push_back(model[nxt]); acc_q.push_back(s_cyc);
                if (first_acc < 0) first_acc = s_cyc;
                last_acc = s_cyc;
                nxt++;
            end
            if (s_xfer) begin
                if (first_beat < 0) first_beat = s_cyc;
                last_beat = s_cyc;
            end
            retire("stream", 1'b1);
        end
        rd_en = 1'b0;
        check("stream_beats", got, 16);
        check("stream_accept_span", last_acc - first_acc, 15);
        check("stream_beat_span", last_beat - first_beat, 15);

        // Byte-enable table: write then read back the resulting word.
        foreach (vecs[i]) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].be);
            read_one(vecs[i].addr, vecs[i].exp, $sformatf("be_vec%0d", i));
        end

        // Backpressure: reads 0..3 with RD_READY low for 6 cycles, then drain.
        for (int a = 0; a < 4; a++) do_write(a, 32'hC0DE0000 + a, 4'hF);
        rd_ready = 1'b0; nxt = 0; got = 0; unstable = 0;
        for (int c = 0; c < 6; c++) begin
            rd_en = (nxt < 4); rd_addr = AW'(nxt);
            cycle();
            if (s_acc) begin
                exp_q.push_back(model[nxt]); acc_q.push_back(s_cyc); nxt++;
            end
            retire("stall", 1'b0);
            if (rd_valid && exp_q.size() > 0 && rd_data !== exp_q[0]) unstable++;
        end
        check("stall_accepts", nxt, LAT);
        check("stall_rd_accept_low", rd_accept, 1'b0);
        check("stall_rd_valid", rd_valid, 1'b1);
        check("stall_rd_data", rd_data, 32'hC0DE0000);
        check("stall_unstable_cycles", unstable, 0);
        rd_ready = 1'b1;
        for (int c = 0; c < 30 && got < 4; c++) begin
            rd_en = (nxt < 4); rd_addr = AW'(nxt);
            cycle();
            if (s_acc) begin
                exp_q.push_back(model[nxt]); acc_q.push_back(s_cyc); nxt++;
            end
            retire("drain", 1'b0);
        end
        rd_en = 1'b0;
        check("drain_delivered", got, 4);
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            cycle();
            if (s_xfer) extra++;
        end
        check("drain_no_duplicates", extra, 0);

        // Same-address write and accepted read on one edge.
        do_write(7, 32'h0, 4'hF);
        wr_en = 1'b1; wr_addr = AW'(7); wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = AW'(7); rd_ready = 1'b1;
        cycle();
        check("collide_accept", s_acc, 1'b1);
        wr_en = 1'b0; rd_en = 1'b0;
        model[7] = 32'hFFFFFFFF;
        wait_beat(d, ok);
        check("collide_beat", ok, 1'b1);
`ifdef RAM_WR_BYPASS_EN
        check("collide_data", d, 32'hFFFFFFFF);
`else
        check("collide_data", d, 32'h00000000);
`endif
        read_one(7, 32'hFFFFFFFF, "collide_after");

        // Reset with two reads in flight; a write during reset must be dropped.
        rd_ready = 1'b0; nxt = 0;
        for (int c = 0; c < 10 && nxt < 2; c++) begin
            rd_en = 1'b1; rd_addr = AW'(nxt + 1);
            cycle();
            if (s_acc) nxt++;
        end
        rd_en = 1'b0;
        check("rst_inflight_accepts", nxt, 2);
        check("rst_inflight_valid", rd_valid, 1'b1);
        rst_n = 1'b0;
        wr_en = 1'b1; wr_addr = AW'(1); wr_data = 32'h5A5A5A5A; wr_be = 4'hF;
        #1;
        check("rst_async_rd_valid", rd_valid, 1'b0);
        check("rst_async_rd_data", rd_data, 32'h0);
        cycle();
        wr_en = 1'b0;
        rst_n = 1'b1;
        rd_ready = 1'b1; extra = 0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            if (s_xfer) extra++;
        end
        check("rst_no_spurious_valid", extra, 0);
        read_one(1, model[1], "rst_mem_kept_a1");
        read_one(2, model[2], "rst_mem_kept_a2");

        // Stalled reads of addr 3 must keep the old word across a later write.
        old_word = model[3];
        rd_ready = 1'b0; nxt = 0;
        for (int c = 0; c < 10 && nxt < LAT; c++) begin
            rd_en = 1'b1; rd_addr = AW'(3);
            cycle();
            if (s_acc) nxt++;
        end
        rd_en = 1'b0;
        check("hold_accepts", nxt, LAT);
        do_write(3, 32'h76543210, 4'hF);
        cycle();
        check("hold_rd_data", rd_data, old_word);
        rd_ready = 1'b1;
        for (int k = 0; k < LAT; k++) begin
            wait_beat(d, ok);
            check($sformatf("hold_beat%0d", k), ok, 1'b1);
            check($sformatf("hold_data%0d", k), d, old_word);
        end
        read_one(3, 32'h76543210, "hold_new_word");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
